altera_tse_pcs_cfg_master: RTL and testbench

ALTERA_TSE_PCS_CFG_MASTER -- requirements
Module: altera_tse_pcs_cfg_master

---
 rtl/altera_tse_pcs_cfg_master.sv | 172 +++++++++++++++++
 tb/tb_altera_tse_pcs_cfg_master.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/altera_tse_pcs_cfg_master.sv
// Register-bus master that configures a TSE PCS (IF_MODE, CONTROL), polls STATUS
// until autonegotiation completes, then monitors the link and restarts AN on loss.
module altera_tse_pcs_cfg_master #(
  parameter bit          ENABLE_SGMII  = 1'b1,
  parameter logic [15:0] IF_MODE_VALUE = 16'h0003,
  parameter logic [15:0] CTRL_VALUE    = 16'h1340,
  parameter int unsigned POLL_INTERVAL = 1000,
  parameter int unsigned TIMEOUT_POLLS = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic [4:0]  address,
  output logic        read,
  output logic        write,
  output logic [15:0] writedata,
  input  logic [15:0] readdata,
  input  logic        waitrequest,
  output logic        busy,
  output logic        done,
  output logic        link_up,
  output logic        fail,
  output logic [15:0] status_last,
  output logic [7:0]  relink_cnt
);

  localparam logic [4:0]  ADDR_CTRL    = 5'h00;
  localparam logic [4:0]  ADDR_STATUS  = 5'h01;
  localparam logic [4:0]  ADDR_IFMODE  = 5'h14;
  localparam logic [31:0] INTERVAL_TOP = 32'(POLL_INTERVAL - 1);
  localparam logic [7:0]  POLL_LIMIT   = 8'(TIMEOUT_POLLS);

  typedef enum logic [3:0] {
    IDLE, WR_IFMODE, WR_CTRL, WAIT_INT, RD_STATUS, DONE, MON_WAIT, MON_RD, FAIL
  } state_t;

  state_t      state, state_n;
  logic [31:0] int_cnt, int_cnt_n;
  logic [7:0]  poll_cnt, poll_cnt_n;
  logic [7:0]  relink_n;
  logic [15:0] status_n;
  logic        link_n;
  logic        xfer_done;
  logic        strobe_ok;
  logic        read_n, write_n;
  logic [4:0]  address_n;
  logic [15:0] writedata_n;

  assign xfer_done = (read | write) & ~waitrequest;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n    = state;
    int_cnt_n  = int_cnt;
    poll_cnt_n = poll_cnt;
    relink_n   = relink_cnt;
    status_n   = status_last;
    link_n     = link_up;
    unique case (state)
      IDLE, FAIL: begin
        if (state == FAIL) link_n = 1'b0;
        if (start) begin
          state_n    = ENABLE_SGMII ? WR_IFMODE : WR_CTRL;
          poll_cnt_n = '0;
        end
      end
      WR_IFMODE: if (xfer_done) state_n = WR_CTRL;
      WR_CTRL: begin
        if (xfer_done) begin
          int_cnt_n = INTERVAL_TOP;
          state_n   = WAIT_INT;
        end
      end
      WAIT_INT, MON_WAIT: begin
        if (int_cnt == '0) state_n = (state == WAIT_INT) ? RD_STATUS : MON_RD;
        else               int_cnt_n = int_cnt - 32'd1;
      end
      RD_STATUS: begin
        if (xfer_done) begin
          status_n = readdata;
          link_n   = readdata[5] & readdata[2];
          if (readdata[5] & readdata[2]) begin
            state_n = DONE;
          end else if (poll_cnt + 8'd1 == POLL_LIMIT) begin
            state_n = FAIL;
          end else begin
            poll_cnt_n = poll_cnt + 8'd1;
            int_cnt_n  = INTERVAL_TOP;
            state_n    = WAIT_INT;
          end
        end
      end
      DONE: begin
        int_cnt_n = INTERVAL_TOP;
        state_n   = MON_WAIT;
      end
      MON_RD: begin
        if (xfer_done) begin
          status_n = readdata;
          link_n   = readdata[5] & readdata[2];
          if (readdata[2]) begin
            int_cnt_n = INTERVAL_TOP;
            state_n   = MON_WAIT;
          end else begin
            link_n     = 1'b0;
            relink_n   = (relink_cnt == 8'hFF) ? relink_cnt : relink_cnt + 8'd1;
            poll_cnt_n = '0;
            state_n    = WR_CTRL;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Strobes are registered from the next state; a completing transfer forces one
  // low cycle, so back-to-back transfers (IF_MODE->CONTROL, MON_RD->CONTROL) get a gap.
  always_comb begin
    strobe_ok   = ~xfer_done;
    write_n     = strobe_ok & ((state_n == WR_IFMODE) | (state_n == WR_CTRL));
    read_n      = strobe_ok & ((state_n == RD_STATUS) | (state_n == MON_RD));
    address_n   = address;
    writedata_n = writedata;
    unique case (state_n)
      WR_IFMODE: begin
        address_n   = ADDR_IFMODE;
        writedata_n = IF_MODE_VALUE;
      end
      WR_CTRL: begin
        address_n   = ADDR_CTRL;
        writedata_n = CTRL_VALUE;
      end
      RD_STATUS, MON_RD: address_n = ADDR_STATUS;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      int_cnt     <= '0;
      poll_cnt    <= '0;
      relink_cnt  <= '0;
      status_last <= '0;
      link_up     <= 1'b0;
      read        <= 1'b0;
      write       <= 1'b0;
      address     <= '0;
      writedata   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fail        <= 1'b0;
    end else begin
      int_cnt     <= int_cnt_n;
      poll_cnt    <= poll_cnt_n;
      relink_cnt  <= relink_n;
      status_last <= status_n;
      link_up     <= link_n;
      read        <= read_n;
      write       <= write_n;
      address     <= address_n;
      writedata   <= writedata_n;
      busy        <= (state_n != IDLE) && (state_n != DONE) && (state_n != FAIL);
      done        <= (state_n == DONE) || (state_n == MON_WAIT) || (state_n == MON_RD);
      fail        <= (state_n == FAIL);
    end
  end

endmodule

// File: tb/tb_altera_tse_pcs_cfg_master.sv
// Directed bench: bus slave with 3-cycle waitrequest, STATUS response queue and
// a scoreboard of expected transfers (kind, address, data, idle gap before it).
module tb_altera_tse_pcs_cfg_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [4:0]  address;
  logic        read, write;
  logic [15:0] writedata;
  logic [15:0] readdata = 16'h0000;
  logic        waitrequest;
  logic        busy, done, link_up, fail;
  logic [15:0] status_last;
  logic [7:0]  relink_cnt;

  altera_tse_pcs_cfg_master #(
    .ENABLE_SGMII (1'b1),
    .IF_MODE_VALUE(16'h0003),
    .CTRL_VALUE   (16'h1340),
    .POLL_INTERVAL(4),
    .TIMEOUT_POLLS(3)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .address    (address),
    .read       (read),
    .write      (write),
    .writedata  (writedata),
    .readdata   (readdata),
    .waitrequest(waitrequest),
    .busy       (busy),
    .done       (done),
    .link_up    (link_up),
    .fail       (fail),
    .status_last(status_last),
    .relink_cnt (relink_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [15:0] data;
    int          gap;
  } xact_t;

  xact_t       exp_q[$];
  logic [15:0] rsp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          xfers = 0;
  int          starts = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_x(input logic wr, input logic [4:0] a, input logic [15:0] d, input int g);
    xact_t x;
    x.wr = wr; x.addr = a; x.data = d; x.gap = g;
    exp_q.push_back(x);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Slave: waitrequest held for the first 3 cycles of every strobe.
  int ws_cnt = 0;
  assign waitrequest = (read | write) && (ws_cnt < 3);
  always @(posedge clk) begin
    if (!(read | write) || !waitrequest) ws_cnt <= 0;
    else                                 ws_cnt <= ws_cnt + 1;
  end

  // Monitor on the falling edge: a strobe with waitrequest low completes at the next rising edge.
  logic        in_xfer = 1'b0, pop_pending = 1'b0, cap_wr;
  logic [4:0]  cap_addr;
  logic [15:0] cap_data;
  int          len = 0, idle_run = 0, cur_gap = 0;
  always @(negedge clk) begin
    xact_t e;
    if (pop_pending) begin
      if (rsp_q.size() != 0) void'(rsp_q.pop_front());
      pop_pending = 1'b0;
    end
    readdata = (rsp_q.size() != 0) ? rsp_q[0] : 16'h0000;
    if (read | write) begin
      if (!in_xfer) begin
        in_xfer = 1'b1; len = 0; cur_gap = idle_run; idle_run = 0; starts++;
        cap_wr = write; cap_addr = address; cap_data = writedata;
      end
      len++;
      chk("rd_wr_exclusive", {31'd0, read & write}, 32'd0);
      chk("addr_stable", {27'd0, address}, {27'd0, cap_addr});
      chk("data_stable", {16'd0, writedata}, {16'd0, cap_data});
      if (!waitrequest) begin
        xfers++;
        if (read) pop_pending = 1'b1;
        chk("strobe_len", len, 32'd4);
        chk("xfer_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("xfer_kind", {31'd0, cap_wr}, {31'd0, e.wr});
          chk("xfer_addr", {27'd0, cap_addr}, {27'd0, e.addr});
          if (e.wr) chk("xfer_data", {16'd0, cap_data}, {16'd0, e.data});
          if (e.gap >= 0) chk("xfer_gap", cur_gap, e.gap);
        end
        in_xfer = 1'b0;
      end
    end else begin
      in_xfer = 1'b0;
      idle_run++;
    end
  end

  initial begin
    int k;
    int x0, s0;
    reset_n = 1'b0;
    start   = 1'b0;
    cycles(3);
    chk("rst_read", {31'd0, read}, 32'd0);
    chk("rst_write", {31'd0, write}, 32'd0);
    chk("rst_address", {27'd0, address}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_status", {16'd0, status_last}, 32'd0);
    reset_n = 1'b1;
    cycles(6);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_no_xfer", starts, 32'd0);

    // Full run: config, 3 polls (3rd succeeds at the timeout boundary), monitor,
    // link loss + relink, second loss, then 3 failed polls -> FAIL.
    rsp_q = '{16'h0000, 16'h0000, 16'h0024, 16'h0024, 16'h0024, 16'h0020, 16'h0024, 16'h0000};
    push_x(1, 5'h14, 16'h0003, -1);
    push_x(1, 5'h00, 16'h1340, 1);
    push_x(0, 5'h01, 16'h0000, 4);
    push_x(0, 5'h01, 16'h0000, 4);
    push_x(0, 5'h01, 16'h0000, 4);
    push_x(0, 5'h01, 16'h0000, 5);
    push_x(0, 5'h01, 16'h0000, 4);
    push_x(0, 5'h01, 16'h0000, 4);
    push_x(1, 5'h00, 16'h1340, 1);
    push_x(0, 5'h01, 16'h0000, 4);
    push_x(0, 5'h01, 16'h0000, 5);
    push_x(1, 5'h00, 16'h1340, 1);
    push_x(0, 5'h01, 16'h0000, 4);
    push_x(0, 5'h01, 16'h0000, 4);
    push_x(0, 5'h01, 16'h0000, 4);
    start = 1'b1; cycles(1); start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);

    k = 0;
    while (xfers < 2 && k < 100) begin cycles(1); k++; end
    chk("tmo_config_writes", xfers, 32'd2);
    cycles(1);
    start = 1'b1; cycles(1); start = 1'b0;   // lands in WAIT_INT, must be ignored

    k = 0;
    while (!done && k < 200) begin cycles(1); k++; end
    chk("done", {31'd0, done}, 32'd1);
    chk("done_busy", {31'd0, busy}, 32'd0);
    chk("done_link_up", {31'd0, link_up}, 32'd1);
    chk("done_status", {16'd0, status_last}, 32'h0024);
    chk("done_reads", xfers, 32'd5);
    cycles(1);
    chk("mon_busy", {31'd0, busy}, 32'd1);
    chk("mon_done", {31'd0, done}, 32'd1);

    k = 0;
    while (relink_cnt != 8'd1 && k < 200) begin cycles(1); k++; end
    chk("relink_1", {24'd0, relink_cnt}, 32'd1);
    chk("loss_link_up", {31'd0, link_up}, 32'd0);
    chk("loss_status", {16'd0, status_last}, 32'h0020);
    chk("loss_done", {31'd0, done}, 32'd0);

    k = 0;
    while (!done && k < 200) begin cycles(1); k++; end
    chk("redone_link_up", {31'd0, link_up}, 32'd1);

    k = 0;
    while (!fail && k < 300) begin cycles(1); k++; end
    chk("fail", {31'd0, fail}, 32'd1);
    chk("fail_busy", {31'd0, busy}, 32'd0);
    chk("fail_link_up", {31'd0, link_up}, 32'd0);
    chk("fail_relink", {24'd0, relink_cnt}, 32'd2);
    chk("fail_status", {16'd0, status_last}, 32'h0000);
    x0 = xfers;
    cycles(20);
    chk("fail_quiet", xfers, x0);
    chk("fail_hold", {31'd0, fail}, 32'd1);
    chk("exp_drained", exp_q.size(), 32'd0);
    chk("rsp_drained", rsp_q.size(), 32'd0);

    // Restart from FAIL, then reset in the middle of the stalled CONTROL write.
    push_x(1, 5'h14, 16'h0003, -1);
    start = 1'b1; cycles(1); start = 1'b0;
    k = 0;
    while (!(write && address == 5'h00) && k < 100) begin cycles(1); k++; end
    chk("ctrl_write_seen", {31'd0, write}, 32'd1);
    chk("ctrl_stalled", {31'd0, waitrequest}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_write", {31'd0, write}, 32'd0);
    chk("arst_writedata", {16'd0, writedata}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_fail", {31'd0, fail}, 32'd0);
    chk("arst_relink", {24'd0, relink_cnt}, 32'd0);
    cycles(2);
    reset_n = 1'b1;
    x0 = xfers; s0 = starts;
    cycles(30);
    chk("post_rst_quiet", starts, s0);
    chk("post_rst_xfers", xfers, x0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("exp_final", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
